temp_sevenseg_scan: RTL

Time-multiplexed seven-segment driver that consumes the sign/BCD result of the temperature display path and scans it onto the board's 8-digit common-anode display. It sits directly downstream of the temperature-to-BCD stage and drives the FPGA display pins. Its behaviour is:
- latch a tear-free snapshot once per scan frame;
- blank leading zeros and place the minus sign adjacent to the leading digit;
- show the unit letter C or F in the rightmost digit.

---
 rtl/temp_sevenseg_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/temp_sevenseg_scan.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans six slots (unit letter, four BCD digits, minus sign) right to left.
// The inputs are snapshotted once per frame, inside a blank window, so no
// digit ever shows a mix of old and new data.
//
// Ports:
//   clk, rst_n        system clock (rising edge) and async active-low reset
//   sign              1 = negative value
//   thou/hund/tens/ones  BCD digits
//   c_f               unit select, 0 = Celsius, 1 = Fahrenheit
//   an                digit anodes, active-low, an[0] is the rightmost digit
//   seg               segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n              decimal point, active-low, always off
//   frame_start       one-cycle pulse for the cycle the snapshot is captured
module temp_sevenseg_scan #(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sign,
  input  logic [3:0] thou,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       c_f,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int unsigned TcntW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TcntW-1:0] TcntMax  = TcntW'(TICKS_PER_DIGIT - 1);
  localparam logic [TcntW-1:0] BlankEnd = TcntW'(BLANK_TICKS);
  localparam logic [2:0]       IdxMax   = 3'd5;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegMinus = 7'h3F;
  localparam logic [6:0] SegC     = 7'h46;
  localparam logic [6:0] SegF     = 7'h0E;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [17:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;

  logic       s_sign, s_cf;
  logic [3:0] s_thou, s_hund, s_tens, s_ones;
  logic       frame_edge;
  logic       thou_on, hund_on, tens_on, show_minus;
  logic [2:0] minus_slot;
  logic [6:0] slot_seg;

  assign {s_sign, s_thou, s_hund, s_tens, s_ones, s_cf} = snap_q;

  // Leading-zero blanking: a digit is shown if it or any digit to its left is
  // nonzero. The minus sign takes the slot just left of the leftmost shown digit.
  assign thou_on    = (s_thou != 4'd0);
  assign hund_on    = thou_on | (s_hund != 4'd0);
  assign tens_on    = hund_on | (s_tens != 4'd0);
  assign show_minus = s_sign & (tens_on | (s_ones != 4'd0));
  assign minus_slot = thou_on ? 3'd5 : hund_on ? 3'd4 : tens_on ? 3'd3 : 3'd2;

  always_comb begin
    slot_seg = SegBlank;
    case (idx_q)
      3'd0: slot_seg = s_cf ? SegF : SegC;
      3'd1: slot_seg = bcd_to_seg(s_ones);
      3'd2: slot_seg = tens_on ? bcd_to_seg(s_tens) :
                       (show_minus && minus_slot == 3'd2) ? SegMinus : SegBlank;
      3'd3: slot_seg = hund_on ? bcd_to_seg(s_hund) :
                       (show_minus && minus_slot == 3'd3) ? SegMinus : SegBlank;
      3'd4: slot_seg = thou_on ? bcd_to_seg(s_thou) :
                       (show_minus && minus_slot == 3'd4) ? SegMinus : SegBlank;
      3'd5: slot_seg = (show_minus && minus_slot == 3'd5) ? SegMinus : SegBlank;
      default: slot_seg = SegBlank;
    endcase
  end

  always_comb begin
    frame_edge    = (tcnt_q == '0) && (idx_q == 3'd0);
    tcnt_d        = tcnt_q + TcntW'(1);
    idx_d         = idx_q;
    snap_d        = snap_q;
    frame_start_d = frame_edge;
    an_d          = 8'hFF;
    seg_d         = SegBlank;

    if (tcnt_q == TcntMax) begin
      tcnt_d = '0;
      idx_d  = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
    end

    // Capture happens while tcnt < BLANK_TICKS, i.e. with all anodes off.
    if (frame_edge) begin
      snap_d = {sign, thou, hund, tens, ones, c_f};
    end

    if (tcnt_q >= BlankEnd) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = slot_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q        <= '0;
      idx_q         <= 3'd0;
      snap_q        <= '0;
      an_q          <= 8'hFF;
      seg_q         <= SegBlank;
      frame_start_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;
  assign dp_n        = 1'b1;

endmodule
